clap_cmd_ctrl: RTL and testbench

//  Sequencer behind the clap detector: groups single-cycle clap pulses into clap bursts and issues one command per burst.
//  - Times each burst, then reports the clap count over a valid/ready handshake.
//  - Enforces a guard (lockout) period after every burst and toggles a lamp output on a double clap.
//  - Sits between the clap detector's clap_pulse_o (already in clk_i domain) and the command consumer / LED logic.

---
 rtl/clap_ctrl_pkg.sv | 15 +
 rtl/clap_cmd_ctrl_if.sv | 8 +
 rtl/clap_ms_timer.sv | 29 ++
 rtl/clap_cmd_ctrl.sv | 97 +++++++++
 tb/tb_clap_cmd_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clap_ctrl_pkg.sv
// clap_ctrl_pkg: shared FSM encoding and sizing helpers for the clap command controller.
package clap_ctrl_pkg;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;
    localparam logic [1:0] S_GUARD   = 2'd3;

    function automatic int ms_to_cycles(input int ms, input int tick_div);
        return ms * tick_div;
    endfunction

    function automatic int cnt_width(input int max_claps);
        return $clog2(max_claps + 1);
    endfunction
endpackage

// File: rtl/clap_cmd_ctrl_if.sv
// clap_cmd_ctrl_if: valid/ready command channel from the clap controller to its consumer.
interface clap_cmd_ctrl_if #(parameter int CNT_W = 3);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_count;
    modport master (output cmd_valid, output cmd_count, input cmd_ready);
    modport slave (input cmd_valid, input cmd_count, output cmd_ready);
endinterface

// File: rtl/clap_ms_timer.sv
// clap_ms_timer: ms prescaler plus saturating ms counter; done_o pulses in the last cycle of term_i ms.
module clap_ms_timer #(
    parameter int TICK_DIV = 100_000,
    parameter int MS_W     = 10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic [MS_W-1:0] term_i,
    output logic            done_o
);
    localparam int P_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [P_W-1:0]  pre;
    logic [MS_W-1:0] ms;
    logic            tick, run;
    assign run    = ms != term_i;
    assign tick   = pre == P_W'(TICK_DIV - 1);
    assign done_o = run && tick && ms == term_i - 1'b1;
    // Counting stops at the terminal ms so done_o fires once per clear.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            pre <= '0;
            ms  <= '0;
        end else if (run) begin
            pre <= tick ? '0 : pre + 1'b1;
            ms  <= ms + MS_W'(tick);
        end
    end
endmodule

// File: rtl/clap_cmd_ctrl.sv
// clap_cmd_ctrl: groups clap pulses into bursts, reports the count over valid/ready, then locks out.
// Define CLAP_MIN_GAP_EN to ignore echo claps closer than MIN_GAP_MS to the previous accepted clap.
module clap_cmd_ctrl
    import clap_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 100_000,
    parameter int WINDOW_MS  = 600,
    parameter int GUARD_MS   = 1000,
    parameter int MIN_GAP_MS = 100,
    parameter int MAX_CLAPS  = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            clap_pulse_i,
    clap_cmd_ctrl_if.master cmd,
    output logic            toggle_o,
    output logic            busy_o
);
    localparam int CNT_W  = cnt_width(MAX_CLAPS);
    localparam int MS_MAX = WINDOW_MS > GUARD_MS ? (WINDOW_MS > MIN_GAP_MS ? WINDOW_MS : MIN_GAP_MS)
                                                 : (GUARD_MS > MIN_GAP_MS ? GUARD_MS : MIN_GAP_MS);
    localparam int MS_W   = $clog2(MS_MAX + 1);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cmd_cnt;
    logic             clap_ok, clap_acc, hs, tmr_clear, tmr_done;
    logic [MS_W-1:0]  tmr_term;

`ifdef CLAP_MIN_GAP_EN
    logic gap_done, gap_ok;
    clap_ms_timer #(.TICK_DIV(TICK_DIV), .MS_W(MS_W)) u_gap (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clap_acc),
        .term_i(MS_W'(MIN_GAP_MS)), .done_o(gap_done)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i || clap_acc) gap_ok <= 1'b0;
        else if (gap_done) gap_ok <= 1'b1;
    end
    assign clap_ok = clap_pulse_i && (state != S_COLLECT || gap_ok || gap_done);
`else
    assign clap_ok = clap_pulse_i;
`endif

    assign clap_acc  = clap_ok && en_i && (state == S_IDLE || state == S_COLLECT);
    assign hs        = cmd.cmd_valid && cmd.cmd_ready;
    assign tmr_clear = state_n != state || clap_acc || state == S_IDLE;
    assign tmr_term  = state == S_GUARD ? MS_W'(GUARD_MS) : MS_W'(WINDOW_MS);

    clap_ms_timer #(.TICK_DIV(TICK_DIV), .MS_W(MS_W)) u_tmr (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(tmr_clear),
        .term_i(tmr_term), .done_o(tmr_done)
    );

    // A clap arriving with the window expiry is checked first, so it extends the burst.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: if (clap_acc) begin
                state_n = S_COLLECT;
                cnt_n   = CNT_W'(1);
            end
            S_COLLECT: if (!en_i) begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end else if (clap_acc) begin
                state_n = cnt == CNT_W'(MAX_CLAPS) ? S_GUARD : S_COLLECT;
                cnt_n   = cnt == CNT_W'(MAX_CLAPS) ? '0 : cnt + 1'b1;
            end else if (tmr_done) state_n = S_REPORT;
            S_REPORT: if (hs) state_n = S_GUARD;
            S_GUARD: begin
                cnt_n = '0;
                if (!en_i || tmr_done) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cmd_cnt  <= '0;
            toggle_o <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == S_COLLECT && state_n == S_REPORT) cmd_cnt <= cnt;
            if (hs && cmd_cnt == CNT_W'(2)) toggle_o <= ~toggle_o;
        end
    end

    assign cmd.cmd_valid = state == S_REPORT;
    assign cmd.cmd_count = cmd_cnt;
    assign busy_o        = state != S_IDLE;
endmodule

// File: tb/tb_clap_cmd_ctrl.sv
// tb_clap_cmd_ctrl: directed and randomized bursts checked against a timeline model of the controller.
module tb_clap_cmd_ctrl;
    localparam int TD = 10, WMS = 5, GMS = 3, GAPMS = 1, MAXC = 3, CW = 2;
    localparam int W = WMS * TD, G = GMS * TD, GAPC = GAPMS * TD;
`ifdef CLAP_MIN_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, en = 1'b1, clap = 1'b0;
    logic toggle, busy;
    int   checks = 0, failures = 0;
    bit   m_tog = 1'b0;
    int   m_cnt = 0;
    int   bt[$];

    clap_cmd_ctrl_if #(.CNT_W(CW)) cif ();

    clap_cmd_ctrl #(
        .TICK_DIV(TD), .WINDOW_MS(WMS), .GUARD_MS(GMS), .MIN_GAP_MS(GAPMS), .MAX_CLAPS(MAXC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clap_pulse_i(clap),
        .cmd(cif), .toggle_o(toggle), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step k drives inputs sampled by clock edge k, then observes the outputs after that edge.
    task automatic run_burst(input int r, input bit extra, input string name);
        int n, last, d, v, h, fin;
        bit disc;
        n = 0; last = 0; d = 0; disc = 1'b0;
        foreach (bt[i]) begin
            int t = bt[i];
            if (n == 0) begin
                n = 1; last = t;
            end else if (!disc && t <= last + W && !(GAP_ON && t - last < GAPC)) begin
                if (n == MAXC) begin
                    disc = 1'b1; d = t;
                end else begin
                    n++; last = t;
                end
            end
        end
        v   = last + W;
        h   = r > v + 1 ? r : v + 1;
        fin = disc ? d + G : h + G;
        if (extra && !disc) bt.push_back(v + int'($urandom_range(1, G)));
        for (int k = 0; k <= fin + 2; k++) begin
            bit c, ev, eb, et;
            int ec;
            c = 1'b0;
            foreach (bt[i]) if (bt[i] == k) c = 1'b1;
            clap = c;
            cif.cmd_ready = k >= r;
            step();
            clap = 1'b0;
            ev = !disc && k >= v && k < h;
            eb = k < fin;
            ec = (!disc && k >= v) ? n : m_cnt;
            et = (!disc && k >= h && n == 2) ? ~m_tog : m_tog;
            checks++;
            if (cif.cmd_valid !== ev) begin
                failures++;
                $display("FAIL %s valid k=%0d got=%b exp=%b", name, k, cif.cmd_valid, ev);
            end
            checks++;
            if (busy !== eb) begin
                failures++;
                $display("FAIL %s busy k=%0d got=%b exp=%b", name, k, busy, eb);
            end
            checks++;
            if (cif.cmd_count !== CW'(ec)) begin
                failures++;
                $display("FAIL %s count k=%0d got=%0d exp=%0d", name, k, cif.cmd_count, ec);
            end
            checks++;
            if (toggle !== et) begin
                failures++;
                $display("FAIL %s toggle k=%0d got=%b exp=%b", name, k, toggle, et);
            end
        end
        cif.cmd_ready = 1'b0;
        if (!disc) begin
            m_tog = m_tog ^ (n == 2);
            m_cnt = n;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks += 4;
        if (cif.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset valid got=%b exp=0", cif.cmd_valid); end
        if (cif.cmd_count !== '0) begin failures++; $display("FAIL reset count got=%0d exp=0", cif.cmd_count); end
        if (toggle !== 1'b0) begin failures++; $display("FAIL reset toggle got=%b exp=0", toggle); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", busy); end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_release busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        bt = '{0};
        run_burst(0, 1'b0, "single");
    endtask

    task automatic test_double();
        bt = '{0, 20};
        run_burst(0, 1'b0, "double_a");
        bt = '{0, 20};
        run_burst(0, 1'b0, "double_b");
    endtask

    task automatic test_backpressure();
        bt = '{0, 55, 60};
        run_burst(65, 1'b0, "backpressure");
    endtask

    task automatic test_overflow();
        bt = '{0, 10, 20, 30, 40};
        run_burst(0, 1'b0, "overflow");
    endtask

    task automatic test_window_edge();
        bt = '{0, 50};
        run_burst(0, 1'b0, "window_edge");
    endtask

    task automatic test_min_gap();
        bt = '{0, 5};
        run_burst(0, 1'b0, "gap_short");
        bt = '{0, 10};
        run_burst(0, 1'b0, "gap_ok");
    endtask

    task automatic test_enable();
        clap = 1'b1;
        step();
        clap = 1'b0;
        repeat (19) step();
        en = 1'b0;
        step();
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL en_collect busy got=%b exp=0", busy); end
        if (cif.cmd_valid !== 1'b0) begin failures++; $display("FAIL en_collect valid got=%b exp=0", cif.cmd_valid); end
        clap = 1'b1;
        step();
        clap = 1'b0;
        for (int k = 0; k < W + 10; k++) begin
            step();
            checks++;
            if (busy !== 1'b0 || cif.cmd_valid !== 1'b0) begin
                failures++;
                $display("FAIL en_low_idle k=%0d busy=%b valid=%b exp=0", k, busy, cif.cmd_valid);
            end
        end
        en = 1'b1;
        step();
        for (int k = 0; k < 35; k++) begin
            clap = k % 10 == 0 && k <= 30;
            step();
        end
        clap = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL en_guard_pre busy got=%b exp=1", busy); end
        en = 1'b0;
        step();
        en = 1'b1;
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL en_guard busy got=%b exp=0", busy); end
        if (cif.cmd_count !== CW'(m_cnt)) begin failures++; $display("FAIL en_guard count got=%0d exp=%0d", cif.cmd_count, m_cnt); end
        step();
    endtask

    task automatic test_reset_mid();
        bt = '{0, 20};
        run_burst(0, 1'b0, "pre_reset");
        clap = 1'b1;
        step();
        clap = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_tog = 1'b0;
        m_cnt = 0;
        checks += 4;
        if (cif.cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_mid valid got=%b exp=0", cif.cmd_valid); end
        if (cif.cmd_count !== '0) begin failures++; $display("FAIL rst_mid count got=%0d exp=0", cif.cmd_count); end
        if (toggle !== 1'b0) begin failures++; $display("FAIL rst_mid toggle got=%b exp=0", toggle); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid busy got=%b exp=0", busy); end
        for (int k = 0; k < W + 10; k++) begin
            step();
            checks++;
            if (cif.cmd_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_after k=%0d valid=%b busy=%b exp=0", k, cif.cmd_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 40; b++) begin
            int nc, t, r;
            nc = $urandom_range(1, MAXC + 1);
            t = 0;
            bt = '{0};
            for (int i = 1; i < nc; i++) begin
                t += ($urandom_range(0, 5) == 0) ? W : int'($urandom_range(1, W));
                bt.push_back(t);
            end
            r = $urandom_range(0, t + W + 20);
            run_burst(r, $urandom_range(0, 1) == 1, "random");
        end
    endtask

    initial begin
        cif.cmd_ready = 1'b0;
        test_reset();
        test_single();
        test_double();
        test_backpressure();
        test_overflow();
        test_window_edge();
        test_min_gap();
        test_enable();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
